// File: rtl/types_pkg.sv
// ---------------------------------------------------------------------------
// types_pkg: shared core types (address/word, fetch entry) and constants.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package types_pkg;

  localparam int MEM_SIZE = 512;

  typedef logic [$clog2(MEM_SIZE)-1:0] address_t;
  typedef logic [31:0]                 word_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

  localparam word_t PC_STEP = 32'd4;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo: synchronous FIFO of fetch_entry_t with flush; head is read
// combinationally. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_fifo
  import types_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  fetch_entry_t     wdata_i,
  output fetch_entry_t     rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
      else if (pop_i && !push_i) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared only by reset; a flush just rewinds the pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage: PC register, instr_mem addressing and {pc,instr} buffering
// toward decode. FETCH_PERF_CNT_EN adds stall/fetch counters. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_stage
  import types_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000,
  parameter int    DEPTH    = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     redirect_valid,
  input  word_t    redirect_pc,
  output address_t imem_addr,
  input  word_t    imem_instr,
  output logic     out_valid,
  input  logic     out_ready,
  output word_t    out_pc,
  output word_t    out_pc_plus4,
`ifdef FETCH_PERF_CNT_EN
  output word_t    stall_cycles,
  output word_t    fetched_count,
`endif
  output word_t    out_instr
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  word_t            pc_q, pc_d;
  logic             w_push, w_pop;
  logic             w_full, w_empty;
  logic [CNT_W-1:0] w_count;
  fetch_entry_t     w_head;

  assign imem_addr = pc_q[$clog2(MEM_SIZE)+1:2];

  assign out_valid = (w_count != '0) && !redirect_valid;
  assign w_pop     = out_valid && out_ready && !w_empty;
  // A push at full is only legal because the head leaves in the same cycle.
  assign w_push    = !redirect_valid && (!w_full || w_pop);

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) pc_d = {redirect_pc[31:2], 2'b00};
    else if (w_push)    pc_d = pc_q + PC_STEP;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .flush_i (redirect_valid),
    .wdata_i ('{pc: pc_q, instr: imem_instr}),
    .rdata_o (w_head),
    .count_o (w_count),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign out_pc       = w_head.pc;
  assign out_instr    = w_head.instr;
  assign out_pc_plus4 = w_head.pc + PC_STEP;

`ifdef FETCH_PERF_CNT_EN
  word_t stall_q, fetched_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q   <= '0;
      fetched_q <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      if (w_push) fetched_q <= fetched_q + 32'd1;
    end
  end

  assign stall_cycles  = stall_q;
  assign fetched_count = fetched_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage: directed vector table, wrap/async-reset sequences and a
// randomized run against a queue-based model of the fetch stage. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fetch_stage;
  import types_pkg::*;

  localparam int DEPTH = 2;

  logic     clk = 1'b0;
  logic     rst;
  logic     redirect_valid;
  word_t    redirect_pc;
  address_t imem_addr;
  word_t    imem_instr;
  logic     out_valid;
  logic     out_ready;
  word_t    out_pc, out_pc_plus4, out_instr;

  logic     redirect_valid_w;
  word_t    redirect_pc_w;
  address_t imem_addr_w;
  word_t    imem_instr_w;
  logic     out_valid_w;
  logic     out_ready_w;
  word_t    out_pc_w, out_pc_plus4_w, out_instr_w;

`ifdef FETCH_PERF_CNT_EN
  word_t stall_cycles, fetched_count, stall_cycles_w, fetched_count_w;
`endif

  always #5 clk = ~clk;

  // Instruction memory: word k holds 0x1000_0000 + k
  assign imem_instr   = 32'h1000_0000 + {23'd0, imem_addr};
  assign imem_instr_w = 32'h1000_0000 + {23'd0, imem_addr_w};

  fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4),
`ifdef FETCH_PERF_CNT_EN
    .stall_cycles   (stall_cycles),
    .fetched_count  (fetched_count),
`endif
    .out_instr      (out_instr)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(DEPTH)) dut_w (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid_w),
    .redirect_pc    (redirect_pc_w),
    .imem_addr      (imem_addr_w),
    .imem_instr     (imem_instr_w),
    .out_valid      (out_valid_w),
    .out_ready      (out_ready_w),
    .out_pc         (out_pc_w),
    .out_pc_plus4   (out_pc_plus4_w),
`ifdef FETCH_PERF_CNT_EN
    .stall_cycles   (stall_cycles_w),
    .fetched_count  (fetched_count_w),
`endif
    .out_instr      (out_instr_w)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic     redir;
    word_t    rpc;
    logic     ready;
    logic     exp_valid;
    word_t    exp_pc;
    address_t exp_addr;
  } vec_t;

  function automatic vec_t mk(input logic r, input word_t rp, input logic rdy,
                              input logic ev, input word_t ep, input int ea);
    vec_t v;
    v.redir = r; v.rpc = rp; v.ready = rdy;
    v.exp_valid = ev; v.exp_pc = ep; v.exp_addr = address_t'(ea);
    return v;
  endfunction

  // Word index that instr_mem sees for a byte pc
  function automatic word_t word_of(input word_t pc);
    return (pc >> 2) % MEM_SIZE;
  endfunction

  vec_t  vecs [15];
  word_t q[$];
  word_t m_pc;
  word_t m_stall, m_fetched;
  logic  ev;

  initial begin
    vecs[0]  = mk(0, 32'h0,  1, 0, 32'h0,  0);
    vecs[1]  = mk(0, 32'h0,  0, 1, 32'h0,  1);
    vecs[2]  = mk(0, 32'h0,  0, 1, 32'h0,  2);
    vecs[3]  = mk(0, 32'h0,  0, 1, 32'h0,  2);
    vecs[4]  = mk(0, 32'h0,  0, 1, 32'h0,  2);
    vecs[5]  = mk(0, 32'h0,  0, 1, 32'h0,  2);
    vecs[6]  = mk(0, 32'h0,  1, 1, 32'h0,  2);
    vecs[7]  = mk(0, 32'h0,  1, 1, 32'h4,  3);
    vecs[8]  = mk(0, 32'h0,  0, 1, 32'h8,  4);
    vecs[9]  = mk(1, 32'h40, 1, 0, 32'h0,  4);
    vecs[10] = mk(0, 32'h0,  1, 0, 32'h0,  16);
    vecs[11] = mk(0, 32'h0,  1, 1, 32'h40, 17);
    vecs[12] = mk(1, 32'h47, 1, 0, 32'h0,  18);
    vecs[13] = mk(0, 32'h0,  1, 0, 32'h0,  17);
    vecs[14] = mk(0, 32'h0,  1, 1, 32'h44, 18);

    rst = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    redirect_valid_w = 1'b0; redirect_pc_w = '0; out_ready_w = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_pc4", out_pc_plus4, 32'h4);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_addr", {23'd0, imem_addr}, 32'd0);
    chk("rst_addr_wrap", {23'd0, imem_addr_w}, 32'd511);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_stall", stall_cycles, 32'd0);
    chk("rst_fetched", fetched_count, 32'd0);
`endif

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].rpc;
      out_ready      = vecs[i].ready;
      #1;
      chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].exp_valid});
      chk($sformatf("v%0d_addr", i), {23'd0, imem_addr}, {23'd0, vecs[i].exp_addr});
      if (vecs[i].exp_valid) begin
        chk($sformatf("v%0d_pc", i), out_pc, vecs[i].exp_pc);
        chk($sformatf("v%0d_pc4", i), out_pc_plus4, vecs[i].exp_pc + 32'd4);
        chk($sformatf("v%0d_instr", i), out_instr, 32'h1000_0000 + word_of(vecs[i].exp_pc));
      end
      if (i == 0) begin
        chk("wrap0_valid", {31'd0, out_valid_w}, 32'd0);
        chk("wrap0_addr", {23'd0, imem_addr_w}, 32'd511);
      end
      if (i == 1) begin
        chk("wrap1_pc", out_pc_w, 32'hFFFF_FFFC);
        chk("wrap1_pc4", out_pc_plus4_w, 32'h0);
        chk("wrap1_instr", out_instr_w, 32'h1000_01FF);
        chk("wrap1_addr", {23'd0, imem_addr_w}, 32'd0);
      end
      if (i == 2) begin
        chk("wrap2_pc", out_pc_w, 32'h0);
        chk("wrap2_addr", {23'd0, imem_addr_w}, 32'd1);
      end
`ifdef FETCH_PERF_CNT_EN
      if (i == 6) begin
        chk("perf_stall5", stall_cycles, 32'd5);
        chk("perf_fetched2", fetched_count, 32'd2);
      end
`endif
      @(negedge clk);
    end

    // Fill the FIFO, then assert reset between clock edges
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("full_valid", {31'd0, out_valid}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_valid", {31'd0, out_valid}, 32'd0);
    chk("async_pc", out_pc, 32'h0);
    chk("async_pc4", out_pc_plus4, 32'h4);
    chk("async_instr", out_instr, 32'h0);
    chk("async_addr", {23'd0, imem_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("restart0_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    #1;
    chk("restart1_valid", {31'd0, out_valid}, 32'd1);
    chk("restart1_pc", out_pc, 32'h0);
    chk("restart1_instr", out_instr, 32'h1000_0000);

    // Randomized run against the queue model
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    m_pc = 32'h0; m_stall = '0; m_fetched = '0;
    for (int c = 0; c < 600; c++) begin
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = (($urandom_range(0, 3) == 0) ? 32'hFFFF_FF00 : 32'h0) | $urandom_range(0, 4095);
      out_ready      = ($urandom_range(0, 2) != 0);
      #1;
      ev = (q.size() != 0) && !redirect_valid;
      chk($sformatf("r%0d_valid", c), {31'd0, out_valid}, {31'd0, ev});
      chk($sformatf("r%0d_addr", c), {23'd0, imem_addr}, word_of(m_pc));
      if (ev) begin
        chk($sformatf("r%0d_pc", c), out_pc, q[0]);
        chk($sformatf("r%0d_pc4", c), out_pc_plus4, q[0] + 32'd4);
        chk($sformatf("r%0d_instr", c), out_instr, 32'h1000_0000 + word_of(q[0]));
      end
      if (redirect_valid) begin
        q.delete();
        m_pc = redirect_pc & ~32'd3;
      end else begin
        if (ev && !out_ready) m_stall++;
        if (ev && out_ready) void'(q.pop_front());
        if (q.size() < DEPTH) begin
          q.push_back(m_pc);
          m_pc = m_pc + 32'd4;
          m_fetched++;
        end
      end
      @(negedge clk);
    end
    #1;
`ifdef FETCH_PERF_CNT_EN
    chk("rand_stall", stall_cycles, m_stall);
    chk("rand_fetched", fetched_count, m_fetched);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Program-counter and fetch stage of the single-cycle/pipelined core; sits directly upstream of instr_mem.
- Generates the word address into instr_mem, captures the combinational instruction read, and buffers {pc, instruction} pairs in a small FIFO toward decode with a valid/ready handshake.
- Accepts redirects (branch/jump/trap targets) from execute, which flush the buffer.

Parameters:
- RESET_PC, 32'h0000_0000, byte address of the first fetch after reset.
- DEPTH, 2, number of {pc, instr} entries in the output FIFO; legal range 2..8, power of two.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- redirect_valid  input  1  load new PC this cycle, flush buffer
- redirect_pc  input  32  redirect target byte address
- imem_addr  output  address_t (9)  word address to instr_mem = pc[10:2]
- imem_instr  input  word_t (32)  instruction returned combinationally by instr_mem
- out_valid  output  1  head FIFO entry valid toward decode
- out_ready  input  1  decode accepts head entry
- out_pc  output  32  byte PC of head entry
- out_pc_plus4  output  32  out_pc + 4, modulo 2^32
- out_instr  output  word_t (32)  instruction of head entry

Behaviour:
- State: pc (32 b), FIFO storage, rd_ptr, wr_ptr, count (0..DEPTH).
- Reset (async assert, sync use after deassert): pc = RESET_PC, pointers = 0, count = 0, all FIFO entries = 0. Consequently out_valid = 0 and out_pc/out_pc_plus4/out_instr = 0 (out_pc_plus4 reads 4 because it is derived).
- imem_addr = pc[10:2], purely combinational. pc[1:0] are ignored for addressing. PC values at or above 2048 alias modulo MEM_SIZE words.
- pop = out_valid & out_ready.
- push = !redirect_valid & (count < DEPTH | pop).
  - Push at full is allowed only with a simultaneous pop.
- On push: write {pc, imem_instr} at wr_ptr; pc <= pc + 4, wrapping at 2^32.
- out_valid = (count != 0) & !redirect_valid.
  - out_valid is combinationally masked during a redirect, so decode never consumes a stale entry in that cycle.
- Redirect (highest priority): count, rd_ptr and wr_ptr are cleared; pc <= {redirect_pc[31:2], 2'b00}; no push, no pop that cycle.
- Latency:
  - After reset release, or cycle N of a redirect, the target is fetched and pushed in the next cycle.
  - It becomes visible on out_valid one cycle after it is pushed: 1 cycle after reset release; cycle N+2 after a redirect.
- Back-pressure:
  - With out_ready = 0, FIFO fills to DEPTH, pc holds, and imem_addr holds.
  - No instruction is dropped or duplicated.
- Steady state: with out_ready = 1 continuously, throughput is one instruction per cycle.
- Pointers wrap modulo DEPTH.
- count update, no redirect:
  - +1 on push only
  - -1 on pop only
  - unchanged on both or neither
- Reset asserted mid-stream: immediate return to reset state; buffered entries are lost.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds output stall_cycles (32 b), reset 0.
  - Increments by 1 in every cycle where out_valid = 1 and out_ready = 0; saturates at 32'hFFFF_FFFF.
  - Adds output fetched_count (32 b), reset 0, which increments on every push and wraps.
- Undefined: neither port exists and no counter logic is synthesized.

Decomposition:
- types_pkg, existing: address_t, word_t, MEM_SIZE.
- types_pkg, to add:
  - typedef fetch_entry_t as a packed struct {word_t pc; word_t instr}.
  - constant PC_STEP = 4.
- One natural sub-module: fetch_fifo, a parameterised synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, flush, count, full, empty.
  - Same clk/rst convention.
- fetch_stage keeps the pc register and the push/redirect control.

Test Plan:
- Reset release, RESET_PC = 0, out_ready = 1, memory word k = 32'h1000_0000 + k: out_pc sequence 0, 4, 8, … one per cycle starting 1 cycle after release; out_instr 0x10000000, 0x10000001, …
- out_ready = 0 for 5 cycles after the first valid: count reaches 2; imem_addr frozen at 2; on release, out_pc continues 0, 4, 8 with no gap or duplicate.
- Redirect to 0x40 while the FIFO holds pc 8 and 0xC: out_valid = 0 that cycle; next valid out_pc = 0x40 (two cycles later) with instr word 16; pc 8 and 0xC never delivered.
- Redirect to 0x47 (misaligned): delivered out_pc = 0x44 and imem_addr = 17.
- PC wrap: RESET_PC = 32'hFFFF_FFFC: out_pc 0xFFFFFFFC then 0x00000000; imem_addr 511 then 0; out_pc_plus4 = 0 for the first entry.
- Async reset mid-stream with FIFO full: outputs drop to reset values in the same cycle without a clock edge; fetch restarts at RESET_PC. With FETCH_PERF_CNT_EN, stall_cycles = 5 after the back-pressure scenario above.
